full_subtractor: RTL and testbench
==================================

Name: full_subtractor

Overview:
- Ripple-borrow subtractor computing diff = x - y - bin, with per-bit borrow-propagate (p) and borrow-generate (g) outputs for a lookahead-borrow unit.
- Used as the subtract primitive inside the ALU.
- Default WIDTH=1 gives the classic 1-bit full subtractor.
- All outputs are registered: one clock, synchronous active-low reset.

Parameters:
- WIDTH, 1, operand width in bits (>=1); bit 0 is LSB and takes bin.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- x  input  WIDTH  minuend
- y  input  WIDTH  subtrahend
- bin  input  1  borrow-in to bit 0
- bout  output  1  borrow-out of MSB (registered)
- diff  output  WIDTH  difference x - y - bin mod 2^WIDTH (registered)
- p  output  WIDTH  per-bit borrow-propagate (registered)
- g  output  WIDTH  per-bit borrow-generate (registered)

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is synchronous and active-low.
- Reset value: at a rising clk with rst_n=0, bout, diff, p and g all load 0. Reset overrides any input sampled in that cycle.
- Per-bit combinational terms, for bit i with borrow b[i] (b[0]=bin):
  - p[i] = ~(x[i] ^ y[i]) (XNOR: the borrow passes when the bits are equal)
  - g[i] = ~x[i] & y[i]
  - d[i] = x[i] ^ y[i] ^ b[i]
  - b[i+1] = g[i] | (p[i] & b[i])
- Outputs: bout = b[WIDTH]. It is 1 exactly when x < y + bin, with x and y treated as unsigned.
- Latency:
  - Every rising clk with rst_n=1 registers d, p, g and b[WIDTH] from the inputs present at that edge.
  - Outputs are valid one cycle after the inputs are applied. The block accepts a new operand set every cycle; there is no handshake.
- No internal state beyond the output registers. No overflow flag; signed overflow is derived elsewhere.
- Wrap-around: 0 - 1 gives diff = all ones and bout = 1.
- p and g depend only on x and y, never on bin.
- Reset mid-stream: the first post-reset output reflects the inputs at the first edge with rst_n=1. Nothing from earlier cycles is retained.
- Inputs with X/Z are not supported. Outputs stay at their reset value until the first valid edge.
- WIDTH=1 truth table (x y bin -> bout diff p g):
  - 1 1 1 -> 1 1 1 0
  - 1 1 0 -> 0 0 1 0
  - 1 0 1 -> 0 0 0 0
  - 1 0 0 -> 0 1 0 0
  - 0 1 1 -> 1 0 0 1
  - 0 1 0 -> 1 1 0 1
  - 0 0 1 -> 1 1 1 0
  - 0 0 0 -> 0 0 1 0

Test Plan:
- Reset: hold rst_n=0 for 2 edges with x=1, y=0, bin=0 -> bout=0, diff=0, p=0, g=0. Release rst_n; one edge later diff=1, bout=0.
- Exhaustive WIDTH=1: apply all 8 (x, y, bin) combinations in the order 111, 110, 101, 100, 011, 010, 001, 000, one per cycle -> each output matches the truth table one cycle after its input.
- Borrow ripple, WIDTH=8: x=0x00, y=0x01, bin=0 -> diff=0xFF, bout=1, p=0xFE, g=0x01.
- Borrow-in only, WIDTH=8: x=0x80, y=0x00, bin=1 -> diff=0x7F, bout=0.
- Equal operands, WIDTH=8: x=y=0x5A, bin=1 -> diff=0xFF, bout=1, p=0xFF, g=0x00.
- Back-to-back throughput plus mid-stream reset:
  - Random x, y, bin each cycle -> outputs track a reference model with exactly 1-cycle latency.
  - Assert rst_n=0 for one cycle -> outputs are 0 on the following cycle, then resume tracking.

Source files
------------

// File: rtl/full_subtractor.sv
// Registered ripple-borrow subtractor: diff = x - y - bin, with per-bit
// borrow-propagate/generate terms exported for a lookahead-borrow unit.

module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic p,
    output logic g,
    output logic bout
);
    // Borrow passes through a bit when its operands are equal.
    assign p    = ~(x ^ y);
    assign g    = ~x & y;
    assign d    = x ^ y ^ bin;
    assign bout = g | (p & bin);
endmodule

module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             bout,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] g
);
    logic [WIDTH:0]   b;
    logic [WIDTH-1:0] d_c;
    logic [WIDTH-1:0] p_c;
    logic [WIDTH-1:0] g_c;

    assign b[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_subtractor_cell u_cell (
            .x    (x[i]),
            .y    (y[i]),
            .bin  (b[i]),
            .d    (d_c[i]),
            .p    (p_c[i]),
            .g    (g_c[i]),
            .bout (b[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bout <= 1'b0;
            diff <= '0;
            p    <= '0;
            g    <= '0;
        end else begin
            bout <= b[WIDTH];
            diff <= d_c;
            p    <= p_c;
            g    <= g_c;
        end
    end
endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH=1 and WIDTH=8, with
// directed cases and random traffic checked against an arithmetic model.

module tb_full_subtractor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       x1, y1, bin1;
    logic       bout1, diff1, p1, g1;
    logic [7:0] x8, y8;
    logic       bin8;
    logic       bout8;
    logic [7:0] diff8, p8, g8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .bin(bin1),
        .bout(bout1), .diff(diff1), .p(p1), .g(g1)
    );

    full_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .x(x8), .y(y8), .bin(bin8),
        .bout(bout8), .diff(diff8), .p(p8), .g(g8)
    );

    // Returns {bout, diff, p, g} for a w-bit subtraction using integer arithmetic.
    function automatic logic [24:0] model(int w, logic [7:0] a, logic [7:0] s, logic bi);
        int          r;
        logic [7:0]  m;
        logic [7:0]  dd;
        m  = 8'((1 << w) - 1);
        r  = int'(a & m) - int'(s & m) - int'(bi);
        dd = 8'(r) & m;
        return {r < 0, dd, ~(a ^ s) & m, ~a & s & m};
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        x1 = 1'b1; y1 = 1'b0; bin1 = 1'b0;
        x8 = 8'h01; y8 = 8'h00; bin8 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            edge_sample();
            n_checks++;
            if ({bout1, diff1, p1, g1} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_w1 edge %0d: got %b want 0000", k, {bout1, diff1, p1, g1});
            end
            n_checks++;
            if ({bout8, diff8, p8, g8} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset_w8 edge %0d: got %h want 0", k, {bout8, diff8, p8, g8});
            end
        end
        rst_n = 1'b1;
        edge_sample();
        n_checks++;
        if ({diff1, bout1} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release_w1: diff=%b bout=%b want diff=1 bout=0", diff1, bout1);
        end
        n_checks++;
        if (diff8 !== 8'h01 || bout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_w8: diff=%h bout=%b want diff=01 bout=0", diff8, bout8);
        end
    endtask

    task automatic test_truth_table();
        // {bout, diff, p, g} for inputs 111, 110, ..., 000 in that order
        logic [3:0] tt [8];
        logic [2:0] in;
        tt = '{4'b1110, 4'b0010, 4'b0000, 4'b0100, 4'b1001, 4'b1101, 4'b1110, 4'b0010};
        for (int k = 0; k < 8; k++) begin
            in = 3'(7 - k);
            {x1, y1, bin1} = in;
            edge_sample();
            n_checks++;
            if ({bout1, diff1, p1, g1} !== tt[k]) begin
                n_fail++;
                $display("FAIL truth_table xyb=%b: got %b want %b", in, {bout1, diff1, p1, g1}, tt[k]);
            end
        end
    endtask

    task automatic test_directed_w8();
        x8 = 8'h00; y8 = 8'h01; bin8 = 1'b0;
        edge_sample();
        n_checks++;
        if ({bout8, diff8, p8, g8} !== {1'b1, 8'hFF, 8'hFE, 8'h01}) begin
            n_fail++;
            $display("FAIL borrow_ripple: got bout=%b diff=%h p=%h g=%h want 1 ff fe 01", bout8, diff8, p8, g8);
        end
        x8 = 8'h80; y8 = 8'h00; bin8 = 1'b1;
        edge_sample();
        n_checks++;
        if (diff8 !== 8'h7F || bout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_in_only: got diff=%h bout=%b want 7f 0", diff8, bout8);
        end
        x8 = 8'h5A; y8 = 8'h5A; bin8 = 1'b1;
        edge_sample();
        n_checks++;
        if ({bout8, diff8, p8, g8} !== {1'b1, 8'hFF, 8'hFF, 8'h00}) begin
            n_fail++;
            $display("FAIL equal_operands: got bout=%b diff=%h p=%h g=%h want 1 ff ff 00", bout8, diff8, p8, g8);
        end
    endtask

    task automatic drive_random(output logic [24:0] exp1, output logic [24:0] exp8);
        x1 = 1'($urandom); y1 = 1'($urandom); bin1 = 1'($urandom);
        x8 = 8'($urandom); y8 = 8'($urandom); bin8 = 1'($urandom);
        exp1 = model(1, {7'd0, x1}, {7'd0, y1}, bin1);
        exp8 = model(8, x8, y8, bin8);
    endtask

    task automatic test_back_to_back();
        logic [24:0] e1, e8;
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                rst_n = 1'b0;
                drive_random(e1, e8);
                edge_sample();
                n_checks++;
                if ({bout1, diff1, p1, g1, bout8, diff8, p8, g8} !== 29'd0) begin
                    n_fail++;
                    $display("FAIL midstream_reset: w1=%b w8=%h want 0", {bout1, diff1, p1, g1},
                             {bout8, diff8, p8, g8});
                end
                rst_n = 1'b1;
            end
            drive_random(e1, e8);
            edge_sample();
            n_checks++;
            if ({bout1, diff1, p1, g1} !== {e1[24], e1[16], e1[8], e1[0]}) begin
                n_fail++;
                $display("FAIL random_w1 cycle %0d: got %b want %b", k, {bout1, diff1, p1, g1},
                         {e1[24], e1[16], e1[8], e1[0]});
            end
            n_checks++;
            if ({bout8, diff8, p8, g8} !== e8) begin
                n_fail++;
                $display("FAIL random_w8 cycle %0d: got %h want %h", k, {bout8, diff8, p8, g8}, e8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_directed_w8();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
